// File: rtl/aes_pkg.sv
// Shared Rijndael state helpers: row shift amounts and a generic ShiftRows/InvShiftRows permutation.
package aes_pkg;

    localparam int unsigned NB_AES = 4;
    localparam int unsigned ROWS   = 4;
    localparam int unsigned MAX_NB = 8;
    localparam int unsigned MAX_W  = 32 * MAX_NB;

    typedef logic [7:0] byte_t;

    // Row shift s_r; the 8-column variant uses the wider offsets for rows 2 and 3.
    function automatic int unsigned shift_amt(input int unsigned nb, input int unsigned r);
        if (nb == 8 && r >= 2) return r + 1;
        return r;
    endfunction

    // State left-aligned in MAX_W bits, byte index 4*c + r counted from the MSB.
    function automatic logic [MAX_W-1:0] permute_state(input logic [MAX_W-1:0] state,
                                                        input int unsigned nb,
                                                        input logic inv);
        logic [MAX_W-1:0] res;
        int unsigned      src_c;
        res = '0;
        for (int unsigned c = 0; c < MAX_NB; c++) begin
            for (int unsigned r = 0; r < ROWS; r++) begin
                if (c < nb) begin
                    src_c = inv ? (c + nb - shift_amt(nb, r)) % nb : (c + shift_amt(nb, r)) % nb;
                    res[MAX_W-1-8*(ROWS*c+r) -: 8] = state[MAX_W-1-8*(ROWS*src_c+r) -: 8];
                end
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/shift_rows_unit_if.sv
// Valid/ready bus of the buffered ShiftRows unit; slave is the unit's view.
interface shift_rows_unit_if #(
    parameter int unsigned NB    = 4,
    parameter int unsigned DEPTH = 2
);
    localparam int unsigned W  = 32 * NB;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic          in_inv;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic          out_inv;
    logic [CW-1:0] count;

    modport master (
        output flush, in_valid, in_data, in_inv, out_ready,
        input  in_ready, out_valid, out_data, out_inv, count
    );

    modport slave (
        input  flush, in_valid, in_data, in_inv, out_ready,
        output in_ready, out_valid, out_data, out_inv, count
    );
endinterface

// File: rtl/shift_rows_fifo.sv
// Synchronous DEPTH-entry FIFO with occupancy count, flush and a registered head word.
module shift_rows_fifo #(
    parameter int unsigned DW    = 129,
    parameter int unsigned DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_flush,
    input  logic                         i_push,
    input  logic [DW-1:0]                i_wdata,
    input  logic                         i_pop,
    output logic [DW-1:0]                o_rdata,
    output logic [$clog2(DEPTH+1)-1:0]   o_count
);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    logic [DW-1:0] r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr, r_rd_ptr;
    logic [CW-1:0] r_count;
    logic [DW-1:0] r_rdata;

    logic [PW-1:0] w_wr_ptr_n, w_rd_ptr_n;
    logic [CW-1:0] w_count_n;
    logic [DW-1:0] w_rdata_n;
    logic          w_we, w_do_push, w_do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST) ? '0 : p + PW'(1);
    endfunction

    // Next state; the head register preloads whichever entry will be at the head next cycle.
    always_comb begin
        w_wr_ptr_n = r_wr_ptr;
        w_rd_ptr_n = r_rd_ptr;
        w_count_n  = r_count;
        w_rdata_n  = r_rdata;
        w_we       = 1'b0;
        w_do_push  = i_push && (r_count != CW'(DEPTH));
        w_do_pop   = i_pop && (r_count != '0);
        if (i_flush) begin
            w_wr_ptr_n = '0;
            w_rd_ptr_n = '0;
            w_count_n  = '0;
            w_rdata_n  = '0;
        end else begin
            if (w_do_push) begin
                w_we       = 1'b1;
                w_wr_ptr_n = ptr_inc(r_wr_ptr);
            end
            if (w_do_pop) w_rd_ptr_n = ptr_inc(r_rd_ptr);
            if (w_do_push && !w_do_pop)      w_count_n = r_count + CW'(1);
            else if (!w_do_push && w_do_pop) w_count_n = r_count - CW'(1);
            if (w_count_n != '0)
                w_rdata_n = (w_do_push && (r_wr_ptr == w_rd_ptr_n)) ? i_wdata : r_mem[w_rd_ptr_n];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_rdata  <= '0;
        end else begin
            r_wr_ptr <= w_wr_ptr_n;
            r_rd_ptr <= w_rd_ptr_n;
            r_count  <= w_count_n;
            r_rdata  <= w_rdata_n;
        end
    end

    // Storage is never cleared; only occupancy tracking is reset.
    always_ff @(posedge clk) begin
        if (w_we && !rst) r_mem[r_wr_ptr] <= i_wdata;
    end

    assign o_rdata = r_rdata;
    assign o_count = r_count;
endmodule

// File: rtl/shift_rows_unit.sv
// Buffered ShiftRows/InvShiftRows stage: combinational permutation feeding an output FIFO.
module shift_rows_unit
    import aes_pkg::*;
#(
    parameter int unsigned NB    = 4,
    parameter int unsigned DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    shift_rows_unit_if.slave bus
);
    localparam int unsigned W  = 32 * NB;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    if (!(NB == 4 || NB == 6 || NB == 8)) begin : g_bad_nb
        $fatal(1, "shift_rows_unit: NB must be 4, 6 or 8");
    end
    if (DEPTH < 1 || DEPTH > 8) begin : g_bad_depth
        $fatal(1, "shift_rows_unit: DEPTH must be 1..8");
    end

    logic [W-1:0]  w_fwd, w_inv, w_perm;
    logic [W:0]    w_rdata;
    logic [CW-1:0] w_count;
    logic          w_in_ready, w_out_valid, w_push, w_pop;

    // Byte 4*c+r counted from the MSB; each output byte is a fixed wire from one input byte.
    for (genvar r = 0; r < ROWS; r++) begin : g_row
        for (genvar c = 0; c < NB; c++) begin : g_col
            localparam int unsigned DST  = W - 1 - 8 * (ROWS * c + r);
            localparam int unsigned FSRC = W - 1 - 8 * (ROWS * ((c + shift_amt(NB, r)) % NB) + r);
            localparam int unsigned ISRC = W - 1 - 8 * (ROWS * ((c + NB - shift_amt(NB, r)) % NB) + r);
            assign w_fwd[DST -: 8] = bus.in_data[FSRC -: 8];
            assign w_inv[DST -: 8] = bus.in_data[ISRC -: 8];
        end
    end

    assign w_perm      = bus.in_inv ? w_inv : w_fwd;
    assign w_in_ready  = (w_count < CW'(DEPTH)) && !bus.flush && !rst;
    assign w_out_valid = (w_count != '0);
    assign w_push      = bus.in_valid && w_in_ready;
    assign w_pop       = w_out_valid && bus.out_ready;

    shift_rows_fifo #(
        .DW    (W + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_flush (bus.flush),
        .i_push  (w_push),
        .i_wdata ({bus.in_inv, w_perm}),
        .i_pop   (w_pop),
        .o_rdata (w_rdata),
        .o_count (w_count)
    );

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.out_data  = w_rdata[W-1:0];
    assign bus.out_inv   = w_rdata[W];
    assign bus.count     = w_count;
endmodule

// File: tb/tb_shift_rows_unit.sv
// Self-checking bench for shift_rows_unit: NB=4/DEPTH=2 and NB=8/DEPTH=3 instances.
module tb_shift_rows_unit;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    typedef struct {
        logic [255:0] d;
        bit           inv;
    } ent_t;

    ent_t q[$];

    always #5 clk = ~clk;

    shift_rows_unit_if #(.NB(4), .DEPTH(2)) b4 ();
    shift_rows_unit_if #(.NB(8), .DEPTH(3)) b8 ();

    shift_rows_unit #(.NB(4), .DEPTH(2)) u4 (.clk(clk), .rst(rst), .bus(b4.slave));
    shift_rows_unit #(.NB(8), .DEPTH(3)) u8 (.clk(clk), .rst(rst), .bus(b8.slave));

    // Reference: state in the low 32*nb bits, byte 4c+r counted from the top of that field.
    function automatic logic [255:0] ref_perm(input logic [255:0] st, input int nb, input bit inv);
        logic [7:0]   m [4][8];
        int           sh [4];
        logic [255:0] res;
        sh  = (nb == 8) ? '{0, 1, 3, 4} : '{0, 1, 2, 3};
        res = '0;
        for (int c = 0; c < nb; c++)
            for (int r = 0; r < 4; r++) m[r][c] = st[32*nb-1-8*(4*c+r) -: 8];
        for (int c = 0; c < nb; c++)
            for (int r = 0; r < 4; r++)
                res[32*nb-1-8*(4*c+r) -: 8] = inv ? m[r][(c - sh[r] + nb) % nb] : m[r][(c + sh[r]) % nb];
        return res;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic xfer4(input logic [127:0] d, input bit inv,
                         output logic [127:0] od, output bit oi, output bit ov);
        b4.in_valid = 1'b1; b4.in_data = d; b4.in_inv = inv; b4.out_ready = 1'b0;
        step();
        b4.in_valid = 1'b0; b4.in_data = {4{$urandom}};
        ov = b4.out_valid; od = b4.out_data; oi = b4.out_inv;
        b4.out_ready = 1'b1;
        step();
        b4.out_ready = 1'b0;
    endtask

    task automatic xfer8(input logic [255:0] d, input bit inv,
                         output logic [255:0] od, output bit oi, output bit ov);
        b8.in_valid = 1'b1; b8.in_data = d; b8.in_inv = inv; b8.out_ready = 1'b0;
        step();
        b8.in_valid = 1'b0; b8.in_data = {8{$urandom}};
        ov = b8.out_valid; od = b8.out_data; oi = b8.out_inv;
        b8.out_ready = 1'b1;
        step();
        b8.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        #1;
        checks++; if (b4.in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready4 got %b want 0", b4.in_ready); end
        checks++; if (b8.in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready8 got %b want 0", b8.in_ready); end
        step();
        rst = 1'b0;
        #1;
        checks++; if (b4.count !== 2'd0) begin errors++; $display("FAIL reset_count got %0d want 0", b4.count); end
        checks++; if (b4.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", b4.out_valid); end
        checks++; if (b4.out_data !== 128'h0 || b4.out_inv !== 1'b0) begin errors++; $display("FAIL reset_out_data got %h/%b want 0/0", b4.out_data, b4.out_inv); end
        checks++; if (b4.in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready got %b want 1", b4.in_ready); end
    endtask

    task automatic test_vectors();
        logic [127:0] od4;
        logic [255:0] od8, seq;
        bit           oi, ov;
        xfer4(128'h9cc52af78b0678f21b8b3ef8e8346d48, 1'b1, od4, oi, ov);
        checks++; if (ov !== 1'b1) begin errors++; $display("FAIL latency_valid got %b want 1", ov); end
        checks++; if (od4 !== 128'h9c343ef28bc56df81b062a48e88b78f7) begin errors++; $display("FAIL inv_vector got %h want 9c343ef28bc56df81b062a48e88b78f7", od4); end
        checks++; if (oi !== 1'b1) begin errors++; $display("FAIL inv_tag got %b want 1", oi); end
        xfer4(128'hd42711aee0bf98f1b8b45de51e415230, 1'b0, od4, oi, ov);
        checks++; if (od4 !== 128'hd4bf5d30e0b452aeb84111f11e2798e5 || oi !== 1'b0) begin errors++; $display("FAIL fips_fwd got %h/%b want d4bf5d30e0b452aeb84111f11e2798e5/0", od4, oi); end
        xfer4(od4, 1'b1, od4, oi, ov);
        checks++; if (od4 !== 128'hd42711aee0bf98f1b8b45de51e415230) begin errors++; $display("FAIL fips_roundtrip got %h want d42711aee0bf98f1b8b45de51e415230", od4); end
        for (int i = 0; i < 32; i++) seq[255-8*i -: 8] = 8'(i);
        xfer8(seq, 1'b0, od8, oi, ov);
        checks++; if (od8[255:192] !== 64'h00050e1304091217) begin errors++; $display("FAIL nb8_fwd_top got %h want 00050e1304091217", od8[255:192]); end
        checks++; if (od8 !== ref_perm(seq, 8, 1'b0)) begin errors++; $display("FAIL nb8_fwd got %h want %h", od8, ref_perm(seq, 8, 1'b0)); end
        xfer8(od8, 1'b1, od8, oi, ov);
        checks++; if (od8 !== seq || oi !== 1'b1) begin errors++; $display("FAIL nb8_roundtrip got %h/%b want %h/1", od8, oi, seq); end
    endtask

    task automatic test_backpressure();
        logic [127:0] a, b, c;
        a = {4{$urandom}}; b = {4{$urandom}}; c = {4{$urandom}};
        b4.out_ready = 1'b0; b4.in_valid = 1'b1; b4.in_inv = 1'b0; b4.in_data = a;
        step();
        b4.in_data = b;
        step();
        b4.in_data = c;
        #1;
        checks++; if (b4.in_ready !== 1'b0 || b4.count !== 2'd2) begin errors++; $display("FAIL full_stall got rdy=%b cnt=%0d want 0/2", b4.in_ready, b4.count); end
        step();
        b4.out_ready = 1'b1;
        #1;
        checks++; if (b4.count !== 2'd2 || b4.in_ready !== 1'b0 || b4.out_data !== ref_perm({128'h0, a}, 4, 1'b0)) begin errors++; $display("FAIL full_pop_head got cnt=%0d rdy=%b d=%h", b4.count, b4.in_ready, b4.out_data); end
        step();
        checks++; if (b4.count !== 2'd1 || b4.out_data !== ref_perm({128'h0, b}, 4, 1'b0)) begin errors++; $display("FAIL second_head got cnt=%0d d=%h", b4.count, b4.out_data); end
        checks++; if (b4.in_ready !== 1'b1) begin errors++; $display("FAIL third_accept got %b want 1", b4.in_ready); end
        step();
        b4.in_valid = 1'b0;
        checks++; if (b4.count !== 2'd1 || b4.out_data !== ref_perm({128'h0, c}, 4, 1'b0)) begin errors++; $display("FAIL third_head got cnt=%0d d=%h", b4.count, b4.out_data); end
        step();
        b4.out_ready = 1'b0;
        checks++; if (b4.count !== 2'd0 || b4.out_valid !== 1'b0) begin errors++; $display("FAIL drained got cnt=%0d v=%b want 0/0", b4.count, b4.out_valid); end
    endtask

    task automatic test_streaming();
        ent_t e;
        q.delete();
        b4.in_valid = 1'b1; b4.out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            e.d = {128'h0, $urandom, $urandom, $urandom, $urandom};
            e.inv = 1'($urandom % 2);
            b4.in_data = e.d[127:0]; b4.in_inv = e.inv;
            #1;
            checks++; if (b4.count !== 2'(q.size()) || b4.in_ready !== 1'b1) begin errors++; $display("FAIL stream_cnt[%0d] got cnt=%0d rdy=%b want %0d/1", i, b4.count, b4.in_ready, q.size()); end
            if (q.size() != 0) begin
                checks++; if (b4.out_data !== q[0].d[127:0] || b4.out_inv !== q[0].inv) begin errors++; $display("FAIL stream_data[%0d] got %h/%b want %h/%b", i, b4.out_data, b4.out_inv, q[0].d[127:0], q[0].inv); end
                void'(q.pop_front());
            end
            q.push_back('{ref_perm(e.d, 4, e.inv), e.inv});
            step();
        end
        b4.in_valid = 1'b0;
        step();
        b4.out_ready = 1'b0;
        q.delete();
    endtask

    task automatic test_reset_flush();
        b4.out_ready = 1'b0; b4.in_valid = 1'b1; b4.in_inv = 1'b1; b4.in_data = {4{$urandom}};
        step(); step();
        b4.in_valid = 1'b0;
        checks++; if (b4.count !== 2'd2) begin errors++; $display("FAIL prefill_rst got %0d want 2", b4.count); end
        rst = 1'b1;
        #1;
        checks++; if (b4.in_ready !== 1'b0) begin errors++; $display("FAIL rst_cycle_ready got %b want 0", b4.in_ready); end
        step();
        rst = 1'b0;
        checks++; if (b4.count !== 2'd0 || b4.out_valid !== 1'b0 || b4.out_data !== 128'h0 || b4.out_inv !== 1'b0) begin errors++; $display("FAIL mid_reset got cnt=%0d v=%b d=%h i=%b", b4.count, b4.out_valid, b4.out_data, b4.out_inv); end
        b4.in_valid = 1'b1;
        step(); step();
        checks++; if (b4.count !== 2'd2) begin errors++; $display("FAIL prefill_flush got %0d want 2", b4.count); end
        b4.flush = 1'b1; b4.out_ready = 1'b1;
        #1;
        checks++; if (b4.in_ready !== 1'b0) begin errors++; $display("FAIL flush_cycle_ready got %b want 0", b4.in_ready); end
        step();
        b4.flush = 1'b0; b4.in_valid = 1'b0; b4.out_ready = 1'b0;
        checks++; if (b4.count !== 2'd0 || b4.out_valid !== 1'b0 || b4.out_data !== 128'h0 || b4.out_inv !== 1'b0) begin errors++; $display("FAIL flush got cnt=%0d v=%b d=%h i=%b", b4.count, b4.out_valid, b4.out_data, b4.out_inv); end
        step();
        checks++; if (b4.count !== 2'd0) begin errors++; $display("FAIL flush_push_void got %0d want 0", b4.count); end
    endtask

    task automatic test_random_nb8();
        ent_t e;
        bit   fl, exp_rdy, pop;
        q.delete();
        for (int i = 0; i < 400; i++) begin
            fl    = ($urandom % 32) == 0;
            e.d   = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            e.inv = 1'($urandom % 2);
            b8.flush = fl; b8.in_valid = 1'($urandom % 4 != 0); b8.out_ready = 1'($urandom % 3 != 0);
            b8.in_data = e.d; b8.in_inv = e.inv;
            #1;
            exp_rdy = !fl && (q.size() < 3);
            checks++; if (b8.in_ready !== exp_rdy || b8.count !== 2'(q.size()) || b8.out_valid !== (q.size() != 0)) begin errors++; $display("FAIL rand_ctrl[%0d] got rdy=%b cnt=%0d v=%b want %b/%0d", i, b8.in_ready, b8.count, b8.out_valid, exp_rdy, q.size()); end
            if (q.size() != 0) begin
                checks++; if (b8.out_data !== q[0].d || b8.out_inv !== q[0].inv) begin errors++; $display("FAIL rand_data[%0d] got %h/%b want %h/%b", i, b8.out_data, b8.out_inv, q[0].d, q[0].inv); end
            end
            pop = (q.size() != 0) && b8.out_ready;
            if (fl) q.delete();
            else begin
                if (pop) void'(q.pop_front());
                if (b8.in_valid && exp_rdy) q.push_back('{ref_perm(e.d, 8, e.inv), e.inv});
            end
            step();
        end
        b8.in_valid = 1'b0; b8.flush = 1'b0; b8.out_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        b4.flush = 1'b0; b4.in_valid = 1'b0; b4.in_data = '0; b4.in_inv = 1'b0; b4.out_ready = 1'b0;
        b8.flush = 1'b0; b8.in_valid = 1'b0; b8.in_data = '0; b8.in_inv = 1'b0; b8.out_ready = 1'b0;
        test_reset();
        test_vectors();
        test_backpressure();
        test_streaming();
        test_reset_flush();
        test_random_nb8();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/shift_rows_unit.md
Name: shift_rows_unit

Overview:
- Parametrised, buffered successor of the combinational inverse-ShiftRows stage.
- Performs Rijndael ShiftRows or InvShiftRows, selected per block, for Nb = 4, 6 or 8 columns.
- Results go into a DEPTH-entry output FIFO with valid/ready handshakes on both sides.
- Sits between SubBytes/InvSubBytes and MixColumns in the encrypt/decrypt round datapath. Absorbs downstream stalls from the SD-card write path.

Parameters:
- NB, 4: state columns; legal values 4, 6, 8. Any other value is a fatal elaboration error.
- DEPTH, 2: output FIFO entries, 1..8.
- W, 32*NB: state width in bits; derived, not overridable.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  synchronous FIFO clear; data is discarded.
- in_valid  in  1  input block present.
- in_ready  out  1  unit accepts the block this cycle.
- in_data  in  W  input state; byte 0 at [W-1:W-8]; column-major, byte index = 4*c + r.
- in_inv  in  1  1 = InvShiftRows, 0 = ShiftRows; sampled with in_data.
- out_valid  out  1  FIFO head is valid.
- out_ready  in  1  downstream consumes the head.
- out_data  out  W  transformed state at the FIFO head.
- out_inv  out  1  mode tag echoed with out_data.
- count  out  $clog2(DEPTH+1)  current FIFO occupancy.

Behaviour:
- Row shifts s_r for r = 0..3:
  - NB = 4 or 6: 0, 1, 2, 3.
  - NB = 8: 0, 1, 3, 4.
- Forward: out[r][c] = in[r][(c + s_r) mod NB].
- Inverse: out[r][c] = in[r][(c - s_r) mod NB].
- Pure byte permutation. The transform is combinational at the input and registered into the FIFO tail.
- Handshake rules:
  - push = in_valid & in_ready.
  - pop = out_valid & out_ready.
  - in_ready = (count < DEPTH) & !flush. in_ready does not depend on out_ready, so a full FIFO accepts nothing even when popping in the same cycle.
- Latency: a block pushed in cycle N appears on out_data with out_valid = 1 in cycle N+1 if the FIFO was empty. There is no combinational in-to-out path.
- Push and pop in the same cycle (count between 1 and DEPTH-1): count is unchanged, head advances, tail advances.
- Pointers are $clog2(DEPTH) wide and wrap from DEPTH-1 to 0; for non-power-of-2 DEPTH the wrap is explicit.
- out_data and out_inv hold their value while out_valid = 1 and out_ready = 0 (AXI-style stability). When out_valid = 0 their values are don't-care; the implementation drives the last head entry.
- in_data is ignored unless push.
- Empty: out_valid = 0, and pop has no effect.
- Full: in_ready = 0, and a held in_valid is not lost; the source keeps asserting it.
- flush:
  - The next cycle has count = 0, out_valid = 0, pointers = 0.
  - Any push or pop in the flush cycle is void.
  - flush has lower priority than rst.
- Reset, including mid-operation: count = 0, out_valid = 0, in_ready = 0 during the rst cycle, out_data = 0, out_inv = 0, pointers = 0.
  - The first push is accepted in the cycle after rst deasserts.
  - FIFO storage is not cleared; only valid tracking is.
- No state machine beyond the FIFO occupancy counter. Occupancy is the single source of truth for in_ready and out_valid.

Decomposition:
- Shared package aes_pkg holds:
  - localparams NB_AES = 4 and ROWS = 4.
  - typedef byte_t = logic [7:0].
  - function shift_amt(nb, r) returning s_r.
  - function permute_state(state, nb, inv), also reused by the standalone combinational stages.
- One sub-module: shift_rows_fifo, a generic W+1-bit, DEPTH-entry synchronous FIFO with count and flush, instantiated once.
- The permutation stays in the top as a generate loop over r and c.

Test Plan:
- NB=4, in_inv=1, in_data=9cc52af78b0678f21b8b3ef8e8346d48 -> one cycle later out_valid=1, out_data=9c343ef28bc56df81b062a48e88b78f7, out_inv=1.
- NB=4, in_inv=0, in_data=d42711aee0bf98f1b8b45de51e415230 (FIPS-197 round 1) -> out_data=d4bf5d30e0b452aeb84111f11e2798e5. Feeding that result back with in_inv=1 returns the original.
- NB=8, in_inv=0, in_data=bytes 00..1f ascending -> out_data bits [255:192]=00050e1304091217. Inverse of that output returns 00..1f.
- DEPTH=2, out_ready=0, push 3 back-to-back blocks -> in_ready drops after 2 pushes, count=2, third block held. Assert out_ready -> blocks emerge in order, one per cycle, third accepted the cycle after the first pop.
- Streaming with in_valid=1, out_ready=1 -> one block per cycle, count stays 1, mixed in_inv tags echoed correctly on out_inv.
- FIFO holding 2 blocks -> assert rst for 1 cycle: next cycle count=0, out_valid=0, out_data=0. Repeat with flush: same result, with in_ready=0 during the flush cycle.
